// File: rtl/bq_wb_pkg.sv
// Shared definitions for Wishbone initiators driving the biquad register port:
// FSM state encoding and default bus geometry / ack timeout.
package bq_wb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } wb_state_t;

   localparam int BQ_AW      = 32;
   localparam int BQ_DW      = 32;
   localparam int BQ_TIMEOUT = 255;

endpackage

// File: rtl/bq_wb_master.sv
// Wishbone classic single-access initiator: one bus cycle per accepted command,
// read data or timeout error returned on a valid/ready response channel.
module bq_wb_master
   import bq_wb_pkg::*;
#(
   parameter int AW      = BQ_AW,
   parameter int DW      = BQ_DW,
   parameter int TIMEOUT = BQ_TIMEOUT
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_i,
   input  logic            cmd_valid_i,
   output logic            cmd_ready_o,
   input  logic            cmd_we_i,
   input  logic [AW-1:0]   cmd_adr_i,
   input  logic [DW-1:0]   cmd_dat_i,
   input  logic [DW/8-1:0] cmd_sel_i,
   output logic            rsp_valid_o,
   input  logic            rsp_ready_i,
   output logic [DW-1:0]   rsp_dat_o,
   output logic            rsp_err_o,
   output logic            wbm_cyc_o,
   output logic            wbm_stb_o,
   output logic            wbm_we_o,
   output logic [AW-1:0]   wbm_adr_o,
   output logic [DW-1:0]   wbm_dat_o,
   output logic [DW/8-1:0] wbm_sel_o,
   input  logic [DW-1:0]   wbm_dat_i,
   input  logic            wbm_ack_i
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   wb_state_t       state_reg, state_next;
   logic [CW-1:0]   cnt_reg, cnt_next;
   logic            cmd_ready_reg, cmd_ready_next;
   logic            rsp_valid_reg, rsp_valid_next;
   logic            rsp_err_reg, rsp_err_next;
   logic [DW-1:0]   rsp_dat_reg, rsp_dat_next;
   logic            cyc_reg, cyc_next;
   logic            we_reg, we_next;
   logic [AW-1:0]   adr_reg, adr_next;
   logic [DW-1:0]   dat_reg, dat_next;
   logic [DW/8-1:0] sel_reg, sel_next;

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      cmd_ready_next = cmd_ready_reg;
      rsp_valid_next = rsp_valid_reg;
      rsp_err_next   = rsp_err_reg;
      rsp_dat_next   = rsp_dat_reg;
      cyc_next       = cyc_reg;
      we_next        = we_reg;
      adr_next       = adr_reg;
      dat_next       = dat_reg;
      sel_next       = sel_reg;

      case (state_reg)
         IDLE: begin
            cmd_ready_next = 1'b1;
            // Acceptance uses the registered ready, so the first edge after reset only raises it.
            if (cmd_valid_i && cmd_ready_reg) begin
               we_next        = cmd_we_i;
               adr_next       = cmd_adr_i;
               dat_next       = cmd_dat_i;
               sel_next       = cmd_sel_i;
               cyc_next       = 1'b1;
               cmd_ready_next = 1'b0;
               cnt_next       = '0;
               state_next     = BUS;
            end
         end
         BUS: begin
            if (wbm_ack_i) begin
               cyc_next       = 1'b0;
               rsp_dat_next   = we_reg ? '0 : wbm_dat_i;
               rsp_err_next   = 1'b0;
               rsp_valid_next = 1'b1;
               state_next     = RESP;
            end else if (cnt_reg == CNT_LAST) begin
               cyc_next       = 1'b0;
               rsp_dat_next   = '0;
               rsp_err_next   = 1'b1;
               rsp_valid_next = 1'b1;
               state_next     = RESP;
            end else if (cnt_reg != '1) begin
               cnt_next = cnt_reg + CNT_ONE;
            end
         end
         RESP: begin
            if (rsp_ready_i) begin
               rsp_valid_next = 1'b0;
               rsp_err_next   = 1'b0;
               cmd_ready_next = 1'b1;
               state_next     = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         cmd_ready_reg <= 1'b0;
         rsp_valid_reg <= 1'b0;
         rsp_err_reg   <= 1'b0;
         rsp_dat_reg   <= '0;
         cyc_reg       <= 1'b0;
         we_reg        <= 1'b0;
         adr_reg       <= '0;
         dat_reg       <= '0;
         sel_reg       <= '0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         cmd_ready_reg <= cmd_ready_next;
         rsp_valid_reg <= rsp_valid_next;
         rsp_err_reg   <= rsp_err_next;
         rsp_dat_reg   <= rsp_dat_next;
         cyc_reg       <= cyc_next;
         we_reg        <= we_next;
         adr_reg       <= adr_next;
         dat_reg       <= dat_next;
         sel_reg       <= sel_next;
      end
   end

   // Classic single access: strobe spans the whole cycle.
   assign wbm_cyc_o   = cyc_reg;
   assign wbm_stb_o   = cyc_reg;
   assign wbm_we_o    = we_reg;
   assign wbm_adr_o   = adr_reg;
   assign wbm_dat_o   = dat_reg;
   assign wbm_sel_o   = sel_reg;
   assign cmd_ready_o = cmd_ready_reg;
   assign rsp_valid_o = rsp_valid_reg;
   assign rsp_err_o   = rsp_err_reg;
   assign rsp_dat_o   = rsp_dat_reg;

endmodule

// File: tb/tb_bq_wb_master.sv
// Directed bench for bq_wb_master (TIMEOUT=8): writes, waited reads, timeout,
// response backpressure, asynchronous reset mid-cycle and streaming.
module tb_bq_wb_master;
   import bq_wb_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready_o;
   logic        cmd_we = 1'b0;
   logic [31:0] cmd_adr = '0;
   logic [31:0] cmd_dat = '0;
   logic [3:0]  cmd_sel = '0;
   logic        rsp_valid_o;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_dat_o;
   logic        rsp_err_o;
   logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
   logic [31:0] wbm_adr_o, wbm_dat_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_dat_i = '0;
   logic        wbm_ack_i = 1'b0;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   bq_wb_master #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
      .wb_clk_i    (clk),
      .wb_rst_i    (rst),
      .cmd_valid_i (cmd_valid),
      .cmd_ready_o (cmd_ready_o),
      .cmd_we_i    (cmd_we),
      .cmd_adr_i   (cmd_adr),
      .cmd_dat_i   (cmd_dat),
      .cmd_sel_i   (cmd_sel),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready),
      .rsp_dat_o   (rsp_dat_o),
      .rsp_err_o   (rsp_err_o),
      .wbm_cyc_o   (wbm_cyc_o),
      .wbm_stb_o   (wbm_stb_o),
      .wbm_we_o    (wbm_we_o),
      .wbm_adr_o   (wbm_adr_o),
      .wbm_dat_o   (wbm_dat_o),
      .wbm_sel_o   (wbm_sel_o),
      .wbm_dat_i   (wbm_dat_i),
      .wbm_ack_i   (wbm_ack_i)
   );

   // Called at a negedge; returns at the negedge of the first strobe cycle.
   task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output bit accepted);
      cmd_valid = 1'b1;
      cmd_we    = we;
      cmd_adr   = adr;
      cmd_dat   = dat;
      cmd_sel   = sel;
      for (int i = 0; i < 20 && !cmd_ready_o; i++) @(negedge clk);
      accepted = cmd_ready_o;
      @(negedge clk);
      cmd_valid = 1'b0;
      $display("[TB] cmd we=%0d adr=%h dat=%h sel=%h", we, adr, dat, sel);
   endtask

   // Counts strobe cycles; acks on strobe cycle ack_at (0 = never ack).
   task automatic wb_run(input int ack_at, input logic [31:0] rdata, output int stb_cycles);
      stb_cycles = 0;
      for (int c = 1; c <= 40; c++) begin
         if (!wbm_stb_o) break;
         stb_cycles++;
         if (c == ack_at) begin
            wbm_ack_i = 1'b1;
            wbm_dat_i = rdata;
         end else begin
            wbm_dat_i = 32'h0BAD_0BAD;
         end
         @(negedge clk);
         wbm_ack_i = 1'b0;
      end
   endtask

   task automatic consume_rsp();
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      tests_run++;
      if ({cmd_ready_o, rsp_valid_o, rsp_err_o, wbm_cyc_o, wbm_stb_o, wbm_we_o} !== 6'b0 ||
          rsp_dat_o !== 32'h0 || wbm_adr_o !== 32'h0 || wbm_dat_o !== 32'h0 || wbm_sel_o !== 4'h0) begin
         tests_failed++;
         $display("FAIL reset_outputs: ctl=%b rsp_dat=%h adr=%h dat=%h sel=%h, required all zero",
                  {cmd_ready_o, rsp_valid_o, rsp_err_o, wbm_cyc_o, wbm_stb_o, wbm_we_o},
                  rsp_dat_o, wbm_adr_o, wbm_dat_o, wbm_sel_o);
      end
      rst = 1'b0;
      #1;
      tests_run++;
      if (cmd_ready_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL ready_before_edge: got %b, required 0", cmd_ready_o);
      end
      @(negedge clk);
      tests_run++;
      if (cmd_ready_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL ready_after_release: got %b, required 1", cmd_ready_o);
      end
      $display("[TB] reset released");
   endtask

   task automatic test_write_zero_wait();
      bit ok;
      int n;
      send_cmd(1'b1, 32'h3000_0004, 32'h0000_1A2B, 4'hF, ok);
      tests_run++;
      if (!ok || wbm_cyc_o !== 1'b1 || wbm_we_o !== 1'b1 || wbm_adr_o !== 32'h3000_0004 ||
          wbm_dat_o !== 32'h0000_1A2B || wbm_sel_o !== 4'hF || cmd_ready_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL write_bus: ok=%0d cyc=%b we=%b adr=%h dat=%h sel=%h rdy=%b, required 1 1 1 30000004 00001a2b f 0",
                  ok, wbm_cyc_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o, cmd_ready_o);
      end
      wb_run(1, 32'h5555_AAAA, n);
      tests_run++;
      if (n != 1) begin
         tests_failed++;
         $display("FAIL write_stb_width: got %0d cycles, required 1", n);
      end
      tests_run++;
      if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0 || rsp_dat_o !== 32'h0) begin
         tests_failed++;
         $display("FAIL write_rsp: valid=%b err=%b dat=%h, required 1 0 00000000", rsp_valid_o, rsp_err_o, rsp_dat_o);
      end
      consume_rsp();
      tests_run++;
      if (rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL write_rsp_done: valid=%b ready=%b, required 0 1", rsp_valid_o, cmd_ready_o);
      end
   endtask

   task automatic test_read_wait();
      bit ok;
      int n;
      send_cmd(1'b0, 32'h3000_0010, 32'h1111_2222, 4'hF, ok);
      wb_run(4, 32'hDEAD_BEEF, n);
      tests_run++;
      if (!ok || n != 4) begin
         tests_failed++;
         $display("FAIL read_stb_width: ok=%0d got %0d cycles, required 4", ok, n);
      end
      tests_run++;
      if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0 || rsp_dat_o !== 32'hDEAD_BEEF ||
          wbm_we_o !== 1'b0 || wbm_adr_o !== 32'h3000_0010) begin
         tests_failed++;
         $display("FAIL read_rsp: valid=%b err=%b dat=%h we=%b adr=%h, required 1 0 deadbeef 0 30000010",
                  rsp_valid_o, rsp_err_o, rsp_dat_o, wbm_we_o, wbm_adr_o);
      end
      consume_rsp();
   endtask

   task automatic test_timeout();
      bit ok;
      int n;
      send_cmd(1'b0, 32'h3000_0020, 32'h0, 4'h3, ok);
      wb_run(0, 32'h0, n);
      tests_run++;
      if (!ok || n != 8) begin
         tests_failed++;
         $display("FAIL timeout_stb_width: ok=%0d got %0d cycles, required 8", ok, n);
      end
      tests_run++;
      if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1 || rsp_dat_o !== 32'h0) begin
         tests_failed++;
         $display("FAIL timeout_rsp: valid=%b err=%b dat=%h, required 1 1 00000000", rsp_valid_o, rsp_err_o, rsp_dat_o);
      end
      consume_rsp();
      send_cmd(1'b1, 32'h3000_0008, 32'h0000_00C3, 4'h1, ok);
      wb_run(2, 32'hFFFF_FFFF, n);
      tests_run++;
      if (!ok || n != 2 || rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0 || rsp_dat_o !== 32'h0) begin
         tests_failed++;
         $display("FAIL after_timeout: ok=%0d stb=%0d valid=%b err=%b dat=%h, required 1 2 1 0 00000000",
                  ok, n, rsp_valid_o, rsp_err_o, rsp_dat_o);
      end
      consume_rsp();
   endtask

   task automatic test_backpressure();
      bit ok;
      int n;
      send_cmd(1'b0, 32'h3000_0030, 32'h0, 4'hF, ok);
      wb_run(1, 32'h1234_5678, n);
      for (int c = 0; c < 10; c++) begin
         tests_run++;
         if (!ok || rsp_valid_o !== 1'b1 || rsp_dat_o !== 32'h1234_5678 || rsp_err_o !== 1'b0 ||
             cmd_ready_o !== 1'b0 || wbm_cyc_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL backpressure_hold[%0d]: valid=%b dat=%h err=%b rdy=%b cyc=%b, required 1 12345678 0 0 0",
                     c, rsp_valid_o, rsp_dat_o, rsp_err_o, cmd_ready_o, wbm_cyc_o);
         end
         wbm_ack_i = (c == 4);
         wbm_dat_i = 32'hFFFF_0000;
         @(negedge clk);
      end
      wbm_ack_i = 1'b0;
      consume_rsp();
      wbm_ack_i = 1'b1;
      wbm_dat_i = 32'hAAAA_5555;
      @(negedge clk);
      wbm_ack_i = 1'b0;
      tests_run++;
      if (rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1 || wbm_cyc_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL idle_spurious_ack: valid=%b rdy=%b cyc=%b, required 0 1 0", rsp_valid_o, cmd_ready_o, wbm_cyc_o);
      end
   endtask

   task automatic test_reset_mid_cycle();
      bit ok;
      send_cmd(1'b0, 32'h3000_0040, 32'h0, 4'hF, ok);
      @(negedge clk);
      rst = 1'b1;
      #1;
      tests_run++;
      if (!ok || {wbm_cyc_o, wbm_stb_o, rsp_valid_o, cmd_ready_o} !== 4'b0) begin
         tests_failed++;
         $display("FAIL async_reset: ok=%0d cyc/stb/valid/rdy=%b, required 0000", ok,
                  {wbm_cyc_o, wbm_stb_o, rsp_valid_o, cmd_ready_o});
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      tests_run++;
      if (cmd_ready_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL ready_after_mid_reset: got %b, required 1", cmd_ready_o);
      end
      wbm_ack_i = 1'b1;
      wbm_dat_i = 32'h7777_7777;
      @(negedge clk);
      wbm_ack_i = 1'b0;
      tests_run++;
      if (wbm_cyc_o !== 1'b0 || rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL late_ack: cyc=%b valid=%b rdy=%b, required 0 0 1", wbm_cyc_o, rsp_valid_o, cmd_ready_o);
      end
      $display("[TB] mid-cycle reset done");
   endtask

   task automatic test_back_to_back();
      logic        s_we  [16];
      logic [31:0] s_adr [16];
      logic [31:0] s_dat [16];
      logic [3:0]  s_sel [16];
      logic [31:0] s_rd  [16];
      logic [31:0] exp_rsp;
      int cmd_idx = 0, bus_idx = 0, rsp_idx = 0, last_bus = 0;
      bit pend = 1'b0;
      for (int i = 0; i < 16; i++) begin
         s_we[i]  = i[0];
         s_adr[i] = 32'h3000_0000 + 32'(i * 4);
         s_dat[i] = 32'h1000_0000 + 32'(i * 32'h0101);
         s_sel[i] = 4'(i + 1);
         s_rd[i]  = 32'hC0DE_0000 | 32'(i);
      end
      rsp_ready = 1'b1;
      for (int cyc = 0; cyc < 200 && rsp_idx < 16; cyc++) begin
         if (pend) cmd_idx++;
         if (wbm_stb_o) begin
            tests_run++;
            if (bus_idx >= 16 || wbm_we_o !== s_we[bus_idx] || wbm_adr_o !== s_adr[bus_idx] ||
                wbm_dat_o !== s_dat[bus_idx] || wbm_sel_o !== s_sel[bus_idx] ||
                (bus_idx > 0 && cyc - last_bus != 3)) begin
               tests_failed++;
               $display("FAIL stream_bus[%0d]: we=%b adr=%h dat=%h sel=%h gap=%0d, required we=%b adr=%h dat=%h sel=%h gap=3",
                        bus_idx, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o, cyc - last_bus,
                        s_we[bus_idx % 16], s_adr[bus_idx % 16], s_dat[bus_idx % 16], s_sel[bus_idx % 16]);
            end
            wbm_ack_i = 1'b1;
            wbm_dat_i = s_rd[bus_idx % 16];
            last_bus  = cyc;
            bus_idx++;
         end else begin
            wbm_ack_i = 1'b0;
            wbm_dat_i = 32'h0BAD_0BAD;
         end
         if (rsp_valid_o) begin
            exp_rsp = s_we[rsp_idx] ? 32'h0 : s_rd[rsp_idx];
            tests_run++;
            if (rsp_dat_o !== exp_rsp || rsp_err_o !== 1'b0) begin
               tests_failed++;
               $display("FAIL stream_rsp[%0d]: dat=%h err=%b, required %h 0", rsp_idx, rsp_dat_o, rsp_err_o, exp_rsp);
            end
            $display("[TB] stream rsp %0d dat=%h", rsp_idx, rsp_dat_o);
            rsp_idx++;
         end
         if (cmd_idx < 16) begin
            cmd_valid = 1'b1;
            cmd_we    = s_we[cmd_idx];
            cmd_adr   = s_adr[cmd_idx];
            cmd_dat   = s_dat[cmd_idx];
            cmd_sel   = s_sel[cmd_idx];
         end else begin
            cmd_valid = 1'b0;
         end
         pend = cmd_valid && cmd_ready_o;
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      wbm_ack_i = 1'b0;
      rsp_ready = 1'b0;
      tests_run++;
      if (bus_idx != 16 || rsp_idx != 16) begin
         tests_failed++;
         $display("FAIL stream_count: bus=%0d rsp=%0d, required 16 16", bus_idx, rsp_idx);
      end
   endtask

   initial begin
      test_reset();
      test_write_zero_wait();
      test_read_wait();
      test_timeout();
      test_backpressure();
      test_reset_mid_cycle();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/bq_wb_master.md
Name: bq_wb_master

Overview:
- Wishbone classic single-access initiator that drives the biquad core's Wishbone responder port (coefficient/state registers) from an on-chip command source: a test sequencer, or a logic-analyser-driven loader.
- Accepts one command at a time over a valid/ready handshake and runs one Wishbone cycle per command.
- Returns the read data, or a timeout error, over a valid/ready response channel.
- Lives in the user project area beside the filter, clocked by the Wishbone clock.

Parameters:
- AW, 32, address width of cmd_adr_i and wbm_adr_o.
- DW, 32, data width of cmd_dat_i, wbm_dat_o, wbm_dat_i and rsp_dat_o.
- TIMEOUT, 255, number of cycles cyc/stb may stay asserted without ack before abort. Legal range 2..65535.

Ports:
- wb_clk_i  in  1  sole clock; all logic is on the rising edge.
- wb_rst_i  in  1  asynchronous, active-high reset.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_adr_i  in  AW  target address.
- cmd_dat_i  in  DW  write data.
- cmd_sel_i  in  DW/8  byte selects.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  response consumed when high with rsp_valid_o.
- rsp_dat_o  out  DW  read data; 0 for writes and on error.
- rsp_err_o  out  1  1 = timed out with no ack.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  Wishbone write enable.
- wbm_adr_o  out  AW  Wishbone address.
- wbm_dat_o  out  DW  Wishbone write data.
- wbm_sel_o  out  DW/8  Wishbone byte selects.
- wbm_dat_i  in  DW  Wishbone read data.
- wbm_ack_i  in  1  Wishbone acknowledge.

Behaviour:
- Clock and reset: one clock, wb_clk_i; reset is asynchronous and active-high on wb_rst_i.
- Reset values: every output is 0, state = IDLE, timeout counter = 0.
  - cmd_ready_o goes to 1 on the first edge after reset deasserts.
- All outputs are registered. There is no combinational path from any input to any output.
- IDLE:
  - cmd_ready_o = 1.
  - On an edge with cmd_valid_i & cmd_ready_o: latch we/adr/dat/sel onto the wbm_* outputs, set wbm_cyc_o = wbm_stb_o = 1, set cmd_ready_o = 0, clear the counter, go to BUS.
  - Request-to-bus latency is 1 cycle.
- BUS:
  - cyc, stb, adr, dat, sel and we are held stable.
  - The counter increments on each edge without ack.
  - Ack branch, on an edge with wbm_ack_i = 1:
    - Deassert cyc and stb.
    - rsp_dat_o = wbm_dat_i for a read, 0 for a write.
    - rsp_err_o = 0, rsp_valid_o = 1.
    - Go to RESP.
  - Timeout branch, taken on the edge where the counter equals TIMEOUT-1 and ack = 0:
    - Deassert cyc and stb.
    - rsp_err_o = 1, rsp_dat_o = 0, rsp_valid_o = 1.
    - Go to RESP.
  - Ack arriving on the same edge as the timeout: ack wins and err = 0.
- Strobe width: stb is high for exactly k cycles when ack is sampled on the k-th edge, with a minimum of 1. It is never high for more than TIMEOUT cycles.
- RESP:
  - rsp_valid_o and the response data are held until an edge with rsp_ready_i = 1.
  - On that edge: rsp_valid_o = 0, rsp_err_o = 0, cmd_ready_o = 1, go to IDLE.
  - Back-to-back commands therefore take at least 3 cycles each.
- wbm_ack_i in IDLE or RESP (stale or spurious) is ignored and does not change state or data.
- cmd_valid_i while cmd_ready_o = 0 is ignored; the source must hold the command.
- wbm_adr_o, wbm_dat_o, wbm_sel_o and wbm_we_o keep their last values after cyc drops. They are don't-care for the responder.
- Reset asserted mid-cycle: cyc and stb drop immediately (asynchronously), any pending response is discarded, and a later ack is ignored.
- The counter is ceil(log2(TIMEOUT)) bits wide and saturates. It never wraps during BUS.

Decomposition:
- Shared package bq_wb_pkg holds:
  - state typedef {IDLE, BUS, RESP};
  - default AW/DW constants (32);
  - TIMEOUT default.
- The package is reused by the bench and any future initiators.
- No sub-module: the FSM, counter and registers form a single module of about 150–200 lines.

Test Plan:
- Write with zero-wait ack: cmd we=1, adr=0x3000_0004, dat=0x0000_1A2B, sel=0xF; responder acks on the first stb cycle. Required: stb high exactly 1 cycle with wbm_dat_o=0x1A2B; rsp_valid with err=0, dat=0.
- Read with 3 wait states: cmd we=0, adr=0x3000_0010; ack on the 4th stb cycle with wbm_dat_i=0xDEAD_BEEF. Required: stb high 4 cycles, rsp_dat_o=0xDEAD_BEEF, err=0.
- Timeout: TIMEOUT=8, responder never acks. Required: cyc/stb high exactly 8 cycles, then rsp_err_o=1, rsp_dat_o=0; the next command is accepted normally.
- Response backpressure: rsp_ready_i held 0 for 10 cycles after a read. Required: rsp_valid/dat stable, cmd_ready_o=0 throughout, and a spurious ack pulse injected meanwhile changes nothing.
- Reset mid-cycle: assert wb_rst_i 2 cycles into BUS. Required: cyc/stb/rsp_valid drop without waiting for a clock edge; cmd_ready_o=1 one edge after release; a late ack is ignored.
- Back-to-back streaming: 16 random commands with cmd_valid always high and rsp_ready always high, zero-wait acks. Required: one Wishbone cycle per command, in order, 3-cycle spacing, all responses matching a scoreboard.
